fpro_dbg_master: RTL and testbench
==================================

# fpro_dbg_master

- Byte-stream-driven initiator on the FPro MMIO bus. It drives the same bus the system bridge drives, from the other end:
  - it issues `fp_mmio_cs`/`fp_wr`/`fp_rd` transactions;
  - it consumes `fp_rd_data`.
- Lets a host read and write any MMIO slot register over a UART byte link with no CPU running.
- Sits beside the bridge in the top level. The top-level mux selects its bus outputs while `dbg_active` is high.

## Interface

Parameters:
- `ADDR_W`, 21: FPro address width.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout in clocks (10 ms at 100 MHz). Used only with `DBG_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle pulse; `rx_data` valid. No backpressure.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte available.
- `tx_ready` in 1: consumer accepts `tx_data` when `tx_valid && tx_ready`.
- `fp_mmio_cs` out 1: MMIO chip select.
- `fp_wr` out 1: write strobe.
- `fp_rd` out 1: read strobe.
- `fp_addr` out `ADDR_W`: bus address.
- `fp_wr_data` out 32: write data.
- `fp_rd_data` in 32: read data from MMIO.
- `dbg_active` out 1: high whenever the FSM is not in IDLE.
- `rx_overrun` out 1: sticky; a byte arrived while not accepting. Cleared only by reset.

## Operation

Frame format, all multi-byte fields MSB first:
- Write: `0x57` ('W'), 3 address bytes, 4 data bytes. Response: `0x4B` ('K').
- Read: `0x52` ('R'), 3 address bytes. Response: 4 data bytes.
- Any other first byte: response `0x3F` ('?'), then back to IDLE.
- Address: upper 24−`ADDR_W` bits are discarded.

FSM states:
- IDLE: on `rx_valid`, latch the opcode.
  - 'W' or 'R' → ADDR.
  - Otherwise load `0x3F` → RESP.
- ADDR: shift in 3 bytes. After the 3rd: 'R' → BUS_RD, 'W' → DATA.
- DATA: shift in 4 bytes, then → BUS_WR.
- BUS_WR: one cycle. `fp_mmio_cs=fp_wr=1`, address and data stable. Load `0x4B`, byte count 1 → RESP.
- BUS_RD: one cycle. `fp_mmio_cs=fp_rd=1`. Capture `fp_rd_data` at the end of this cycle, byte count 4 → RESP.
- RESP: present bytes MSB first. Advance on each `tx_valid && tx_ready`. After the last byte → IDLE.

Byte acceptance and bus drive:
- `rx_valid` is honoured only in IDLE, ADDR and DATA.
- `rx_valid` in BUS_RD, BUS_WR or RESP drops the byte and sets `rx_overrun`.
- `fp_addr` and `fp_wr_data` hold their last values outside bus states.
- Strobes are 0 outside BUS_WR and BUS_RD.

## Timing

- Reset values:
  - state IDLE;
  - all bus outputs 0, `tx_data=0`, `tx_valid=0`;
  - `dbg_active=0`, `rx_overrun=0`.
- Reset mid-frame or mid-response aborts immediately with no bus strobe issued.
- Byte capture:
  - A byte is registered on the edge where `rx_valid=1`.
  - After the last write-data byte: BUS_WR is the next cycle.
  - After the 3rd address byte of a read: BUS_RD is the next cycle.
- Exactly one strobe cycle per frame.
- `fp_rd_data` must be valid combinationally during the BUS_RD cycle.
- `tx_valid` rises the cycle after the bus cycle, or the cycle after an invalid opcode is received.
- `tx_valid` and `tx_data` hold stable until accepted.
- With `tx_ready` held high, one byte is accepted per cycle.
- IDLE is re-entered the cycle after the final handshake.
- A byte arriving in that same cycle is dropped and counted as overrun.

## Configuration

`DBG_TIMEOUT_EN`:
- Defined:
  - A counter clears on every accepted byte and counts while in ADDR or DATA.
  - On reaching `TIMEOUT_CYCLES` the FSM returns to IDLE: no bus cycle, no response.
- Undefined:
  - No counter.
  - A partial frame waits indefinitely for its remaining bytes.

## Structure

- Shared package `fpro_dbg_pkg` holds:
  - state enum `dbg_state_t`;
  - opcode constants `OP_WR=8'h57`, `OP_RD=8'h52`;
  - response constants `RSP_ACK=8'h4B`, `RSP_ERR=8'h3F`.
- Sub-module `dbg_tx_shifter`: 4-byte response register, byte counter and `tx_valid`/`tx_ready` handshake. Loaded with a word and a byte count.
- The top of the block holds the FSM, address/data assembly, bus drive and the optional timeout.

## Test plan

- Write frame `57 00 00 04 DE AD BE EF`:
  - exactly one cycle with `fp_mmio_cs=fp_wr=1`, `fp_addr=0x000004`, `fp_wr_data=0xDEADBEEF`;
  - then response `4B`.
- Read frame `52 00 01 00` with `fp_rd_data=0x12345678`:
  - one cycle with `fp_rd=1`, `fp_addr=0x000100`;
  - response `12 34 56 78`.
- Address bytes `FF FF FF`: `fp_addr=0x1FFFFF` (upper bits discarded).
- Opcode `0x41`: response `3F`, no strobe; a following valid read succeeds.
- `tx_ready` low for 20 cycles during a read response: `tx_data=0x12` held; all 4 bytes delivered in order afterwards.
- Byte injected during RESP: byte dropped, `rx_overrun=1` until reset.
- With `DBG_TIMEOUT_EN` and `TIMEOUT_CYCLES=100`: send `57 00`, idle 100 cycles.
  - FSM returns to IDLE with no strobe and no response.
  - A subsequent full write completes.

Source files
------------

// File: rtl/fpro_dbg_pkg.sv
// Shared types and byte constants for the FPro byte-stream debug master.
package fpro_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RESP
    } dbg_state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    localparam logic [2:0] RSP_WORD_BYTES = 3'd4;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/dbg_tx_shifter.sv
// Response shifter: holds up to four bytes and presents them MSB first on a
// valid/ready byte interface.
module dbg_tx_shifter
    import fpro_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic [2:0]  load_count,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last
);

    logic [31:0] word_q;
    logic [2:0]  cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            cnt_q    <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            word_q   <= load_word;
            cnt_q    <= (load_count > RSP_WORD_BYTES) ? RSP_WORD_BYTES : load_count;
            tx_valid <= (load_count != 3'd0);
        end else if (tx_valid && tx_ready) begin
            word_q <= {word_q[23:0], 8'h00};
            cnt_q  <= cnt_q - 3'd1;
            if (cnt_q == 3'd1)
                tx_valid <= 1'b0;
        end
    end

    assign tx_data = word_q[31:24];
    assign tx_last = (cnt_q == 3'd1);

endmodule

// File: rtl/fpro_dbg_master.sv
// UART-byte-driven FPro MMIO initiator: 'W' aaa dddd writes, 'R' aaa reads.
// Optional inter-byte timeout is built when DBG_TIMEOUT_EN is defined.
//
// state     | meaning
// ----------+----------------------------------------------------
// ST_IDLE   | waiting for an opcode byte
// ST_ADDR   | collecting 3 address bytes, MSB first
// ST_DATA   | collecting 4 write-data bytes, MSB first
// ST_BUS_WR | single write strobe cycle
// ST_BUS_RD | single read strobe cycle, fp_rd_data captured
// ST_RESP   | response bytes draining through the tx shifter
module fpro_dbg_master
    import fpro_dbg_pkg::*;
#(
    parameter int ADDR_W         = 21,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              fp_mmio_cs,
    output logic              fp_wr,
    output logic              fp_rd,
    output logic [ADDR_W-1:0] fp_addr,
    output logic [31:0]       fp_wr_data,
    input  logic [31:0]       fp_rd_data,
    output logic              dbg_active,
    output logic              rx_overrun
);

    dbg_state_t        state;
    logic              is_rd;
    logic [1:0]        byte_cnt;
    logic [15:0]       addr_sr;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic [23:0]       data_sr;
    logic              accepting;
    logic              timeout;

    logic              tx_load;
    logic [31:0]       tx_word;
    logic [2:0]        tx_count;
    logic              tx_last;

    assign accepting  = (state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA);
    assign dbg_active = (state != ST_IDLE);
    assign addr_next  = ADDR_W'({addr_sr, rx_data});

`ifdef DBG_TIMEOUT_EN
    localparam int              TO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset || (rx_valid && accepting))
            to_cnt <= TO_RELOAD;
        else if (((state == ST_ADDR) || (state == ST_DATA)) && (to_cnt != '0))
            to_cnt <= to_cnt - TO_W'(1);
    end

    assign timeout = ((state == ST_ADDR) || (state == ST_DATA)) && !rx_valid && (to_cnt == '0);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    always_comb begin
        tx_load  = 1'b0;
        tx_word  = '0;
        tx_count = '0;
        case (state)
            ST_IDLE: if (rx_valid && !is_opcode(rx_data)) begin
                tx_load  = 1'b1;
                tx_word  = {RSP_ERR, 24'h0};
                tx_count = 3'd1;
            end
            ST_BUS_WR: begin
                tx_load  = 1'b1;
                tx_word  = {RSP_ACK, 24'h0};
                tx_count = 3'd1;
            end
            ST_BUS_RD: begin
                tx_load  = 1'b1;
                tx_word  = fp_rd_data;
                tx_count = RSP_WORD_BYTES;
            end
            default: ;
        endcase
    end

    // Strobes are registered: they are raised on the edge entering a bus state
    // and dropped by the default assignment on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            is_rd      <= 1'b0;
            byte_cnt   <= '0;
            addr_sr    <= '0;
            addr_q     <= '0;
            data_sr    <= '0;
            fp_mmio_cs <= 1'b0;
            fp_wr      <= 1'b0;
            fp_rd      <= 1'b0;
            fp_addr    <= '0;
            fp_wr_data <= '0;
            rx_overrun <= 1'b0;
        end else begin
            fp_mmio_cs <= 1'b0;
            fp_wr      <= 1'b0;
            fp_rd      <= 1'b0;
            if (rx_valid && !accepting)
                rx_overrun <= 1'b1;

            case (state)
                ST_IDLE: if (rx_valid) begin
                    byte_cnt <= '0;
                    is_rd    <= (rx_data == OP_RD);
                    state    <= is_opcode(rx_data) ? ST_ADDR : ST_RESP;
                end
                ST_ADDR: if (rx_valid) begin
                    addr_sr  <= {addr_sr[7:0], rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd2) begin
                        byte_cnt <= '0;
                        if (is_rd) begin
                            state      <= ST_BUS_RD;
                            fp_mmio_cs <= 1'b1;
                            fp_rd      <= 1'b1;
                            fp_addr    <= addr_next;
                        end else begin
                            state  <= ST_DATA;
                            addr_q <= addr_next;
                        end
                    end
                end else if (timeout) begin
                    state <= ST_IDLE;
                end
                ST_DATA: if (rx_valid) begin
                    data_sr  <= {data_sr[15:0], rx_data};
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state      <= ST_BUS_WR;
                        fp_mmio_cs <= 1'b1;
                        fp_wr      <= 1'b1;
                        fp_addr    <= addr_q;
                        fp_wr_data <= {data_sr, rx_data};
                    end
                end else if (timeout) begin
                    state <= ST_IDLE;
                end
                ST_BUS_WR: state <= ST_RESP;
                ST_BUS_RD: state <= ST_RESP;
                ST_RESP: if (tx_valid && tx_ready && tx_last)
                    state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    dbg_tx_shifter u_tx (
        .clk        (clk),
        .reset      (reset),
        .load       (tx_load),
        .load_word  (tx_word),
        .load_count (tx_count),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last)
    );

endmodule

// File: tb/tb_fpro_dbg_master.sv
// Self-checking bench for fpro_dbg_master: directed frames plus random frames
// compared against a frame-level model of bus effect and response bytes.
module tb_fpro_dbg_master;

    localparam int ADDR_W = 21;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              fp_mmio_cs;
    logic              fp_wr;
    logic              fp_rd;
    logic [ADDR_W-1:0] fp_addr;
    logic [31:0]       fp_wr_data;
    logic [31:0]       fp_rd_data = 32'h0;
    logic              dbg_active;
    logic              rx_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    fpro_dbg_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fp_mmio_cs (fp_mmio_cs),
        .fp_wr      (fp_wr),
        .fp_rd      (fp_rd),
        .fp_addr    (fp_addr),
        .fp_wr_data (fp_wr_data),
        .fp_rd_data (fp_rd_data),
        .dbg_active (dbg_active),
        .rx_overrun (rx_overrun)
    );

    always #5 clk = ~clk;

    // Bus monitor: every chip-select cycle is one strobe.
    int              strobe_cnt = 0;
    int              bad_strobe = 0;
    logic            last_wr = 1'b0;
    logic            last_rd = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [31:0]     last_wdata = '0;

    always @(negedge clk) begin
        if (fp_mmio_cs === 1'b1) begin
            strobe_cnt++;
            last_wr    = fp_wr;
            last_rd    = fp_rd;
            last_addr  = fp_addr;
            last_wdata = fp_wr_data;
            if (fp_wr === fp_rd) bad_strobe++;
        end else if ((fp_wr === 1'b1) || (fp_rd === 1'b1)) begin
            bad_strobe++;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic collect(input int n, input bit rand_ready, output logic [31:0] got, output int ngot);
        int budget = 400;
        got  = '0;
        ngot = 0;
        while (ngot < n && budget > 0) begin
            @(negedge clk);
            tx_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            if (tx_valid && tx_ready) begin
                got = {got[23:0], tx_data};
                ngot++;
            end
            budget--;
        end
    endtask

    // Model: 'W' -> one write of wdata to addr, reply 4B; 'R' -> one read, reply
    // the four rd_data bytes MSB first; anything else -> reply 3F, no bus cycle.
    task automatic run_frame(input string name, input logic [7:0] op, input logic [23:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int gap_max, input bit rand_ready);
        int          s0, b0, ngot, exp_n, exp_strobes;
        logic [31:0] got, exp_word;
        logic [ADDR_W-1:0] exp_addr;
        bit          is_wr, is_rd;
        is_wr       = (op == 8'h57);
        is_rd       = (op == 8'h52);
        exp_addr    = addr[ADDR_W-1:0];
        exp_n       = is_rd ? 4 : 1;
        exp_word    = is_wr ? 32'h4B : (is_rd ? rdata : 32'h3F);
        exp_strobes = (is_wr || is_rd) ? 1 : 0;
        fp_rd_data  = rdata;
        tx_ready    = 1'b0;
        s0          = strobe_cnt;
        b0          = bad_strobe;

        send_byte(op);
        if (is_wr || is_rd)
            for (int i = 0; i < 3; i++) begin
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
                send_byte(addr[23 - 8*i -: 8]);
            end
        if (is_wr)
            for (int i = 0; i < 4; i++) begin
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
                send_byte(wdata[31 - 8*i -: 8]);
            end

        collect(exp_n, rand_ready, got, ngot);
        @(negedge clk);
        tx_ready = 1'b0;

        n_checks++;
        if (ngot !== exp_n) $display("FAIL %s resp_count: got %0d want %0d", name, ngot, exp_n);
        else n_pass++;
        n_checks++;
        if (got !== exp_word) $display("FAIL %s resp_bytes: got %08h want %08h", name, got, exp_word);
        else n_pass++;
        n_checks++;
        if ((strobe_cnt - s0) !== exp_strobes || bad_strobe !== b0)
            $display("FAIL %s strobes: got %0d (bad %0d) want %0d (bad 0)", name, strobe_cnt - s0, bad_strobe - b0, exp_strobes);
        else n_pass++;
        if (exp_strobes == 1) begin
            n_checks++;
            if (last_wr !== is_wr || last_rd !== is_rd || last_addr !== exp_addr)
                $display("FAIL %s bus_cycle: wr=%0b rd=%0b addr=%06h want wr=%0b rd=%0b addr=%06h",
                         name, last_wr, last_rd, last_addr, is_wr, is_rd, exp_addr);
            else n_pass++;
        end
        if (is_wr) begin
            n_checks++;
            if (last_wdata !== wdata) $display("FAIL %s wr_data: got %08h want %08h", name, last_wdata, wdata);
            else n_pass++;
        end
        n_checks++;
        if (dbg_active !== 1'b0 || tx_valid !== 1'b0)
            $display("FAIL %s back_to_idle: dbg_active=%0b tx_valid=%0b want 0 0", name, dbg_active, tx_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({fp_mmio_cs, fp_wr, fp_rd} !== 3'b000) $display("FAIL reset strobes: got %03b want 000", {fp_mmio_cs, fp_wr, fp_rd});
        else n_pass++;
        n_checks++;
        if (fp_addr !== '0) $display("FAIL reset fp_addr: got %06h want 0", fp_addr);
        else n_pass++;
        n_checks++;
        if (fp_wr_data !== 32'h0) $display("FAIL reset fp_wr_data: got %08h want 0", fp_wr_data);
        else n_pass++;
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL reset tx: valid=%0b data=%02h want 0 00", tx_valid, tx_data);
        else n_pass++;
        n_checks++;
        if (dbg_active !== 1'b0 || rx_overrun !== 1'b0)
            $display("FAIL reset status: dbg_active=%0b rx_overrun=%0b want 0 0", dbg_active, rx_overrun);
        else n_pass++;
    endtask

    task automatic test_write_timing();
        logic [7:0] frame [8];
        int s0;
        frame = '{8'h57, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tx_ready = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < 8; i++) send_byte(frame[i]);
        n_checks++;
        if (fp_mmio_cs !== 1'b1 || fp_wr !== 1'b1 || fp_rd !== 1'b0 || fp_addr !== 21'h000004 || fp_wr_data !== 32'hDEADBEEF)
            $display("FAIL write bus_cycle: cs=%0b wr=%0b rd=%0b addr=%06h data=%08h want 1 1 0 000004 deadbeef",
                     fp_mmio_cs, fp_wr, fp_rd, fp_addr, fp_wr_data);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (fp_mmio_cs !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B)
            $display("FAIL write resp_start: cs=%0b tx_valid=%0b tx_data=%02h want 0 1 4b", fp_mmio_cs, tx_valid, tx_data);
        else n_pass++;
        n_checks++;
        if (fp_addr !== 21'h000004 || fp_wr_data !== 32'hDEADBEEF)
            $display("FAIL write hold: addr=%06h data=%08h want 000004 deadbeef", fp_addr, fp_wr_data);
        else n_pass++;
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b0 || dbg_active !== 1'b0 || (strobe_cnt - s0) !== 1)
            $display("FAIL write finish: tx_valid=%0b dbg_active=%0b strobes=%0d want 0 0 1", tx_valid, dbg_active, strobe_cnt - s0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          held_bad = 0;
        int          ngot;
        logic [31:0] got;
        fp_rd_data = 32'h12345678;
        tx_ready   = 1'b0;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== 8'h12) held_bad++;
        end
        n_checks++;
        if (held_bad != 0) $display("FAIL backpressure hold: %0d cycles not showing valid 12, want 0", held_bad);
        else n_pass++;
        collect(4, 1'b0, got, ngot);
        @(negedge clk);
        tx_ready = 1'b0;
        n_checks++;
        if (ngot !== 4 || got !== 32'h12345678) $display("FAIL backpressure bytes: got %0d/%08h want 4/12345678", ngot, got);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int          ngot;
        logic [31:0] got;
        fp_rd_data = 32'hCAFE0155;
        tx_ready   = 1'b0;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h08);
        @(negedge clk);
        send_byte(8'h57);
        n_checks++;
        if (rx_overrun !== 1'b1 || tx_data !== 8'hCA) $display("FAIL overrun set: overrun=%0b tx_data=%02h want 1 ca", rx_overrun, tx_data);
        else n_pass++;
        collect(4, 1'b1, got, ngot);
        @(negedge clk);
        tx_ready = 1'b0;
        n_checks++;
        if (ngot !== 4 || got !== 32'hCAFE0155 || dbg_active !== 1'b0)
            $display("FAIL overrun resp: got %0d/%08h active=%0b want 4/cafe0155 0", ngot, got, dbg_active);
        else n_pass++;
        run_frame("overrun_next", 8'h57, 24'h000010, 32'h0BADF00D, 32'h0, 1, 1'b0);
        n_checks++;
        if (rx_overrun !== 1'b1) $display("FAIL overrun sticky: got %0b want 1", rx_overrun);
        else n_pass++;
        apply_reset();
        n_checks++;
        if (rx_overrun !== 1'b0) $display("FAIL overrun clear: got %0b want 0", rx_overrun);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        s0 = strobe_cnt;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        apply_reset();
        n_checks++;
        if (dbg_active !== 1'b0 || (strobe_cnt - s0) !== 0)
            $display("FAIL reset_mid_frame: active=%0b strobes=%0d want 0 0", dbg_active, strobe_cnt - s0);
        else n_pass++;
        fp_rd_data = 32'hA5A5A5A5;
        tx_ready   = 1'b0;
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h20);
        @(negedge clk);
        apply_reset();
        n_checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || dbg_active !== 1'b0)
            $display("FAIL reset_mid_resp: tx_valid=%0b tx_data=%02h active=%0b want 0 00 0", tx_valid, tx_data, dbg_active);
        else n_pass++;
        run_frame("after_reset_write", 8'h57, 24'h000044, 32'h01020304, 32'h0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(3, 0))
                0, 1:    op = 8'h57;
                2:       op = 8'h52;
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h57 || op == 8'h52) op = 8'h00;
                end
            endcase
            run_frame("random", op, 24'($urandom), $urandom, $urandom, 3, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++)
            run_frame("back_to_back", (k % 2 == 0) ? 8'h52 : 8'h57, 24'($urandom), $urandom, $urandom, 0, 1'b0);
    endtask

`ifdef DBG_TIMEOUT_EN
    task automatic test_timeout();
        int s0;
        s0 = strobe_cnt;
        tx_ready = 1'b0;
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (102) @(negedge clk);
        n_checks++;
        if (dbg_active !== 1'b0 || tx_valid !== 1'b0 || (strobe_cnt - s0) !== 0)
            $display("FAIL timeout abort: active=%0b tx_valid=%0b strobes=%0d want 0 0 0", dbg_active, tx_valid, strobe_cnt - s0);
        else n_pass++;
        run_frame("timeout_next", 8'h57, 24'h000008, 32'h55AA55AA, 32'h0, 0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_write_timing();
        run_frame("read", 8'h52, 24'h000100, 32'h0, 32'h12345678, 0, 1'b0);
        run_frame("addr_trunc_rd", 8'h52, 24'hFFFFFF, 32'h0, 32'h87654321, 0, 1'b0);
        run_frame("addr_trunc_wr", 8'h57, 24'hFFFFFF, 32'hFEEDFACE, 32'h0, 2, 1'b0);
        run_frame("bad_opcode", 8'h41, 24'h0, 32'h0, 32'h0, 0, 1'b0);
        run_frame("read_after_bad", 8'h52, 24'h000200, 32'h0, 32'h9ABCDEF0, 0, 1'b0);
        test_backpressure();
        test_overrun();
        test_reset_mid_frame();
`ifdef DBG_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
